spsram32_dma: RTL and testbench
===============================

SPSRAM32_DMA -- requirements
Module: spsram32_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the word-count input.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a transfer; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancel an in-flight transfer.
REQ-006 SHALL have port src_addr  input  32  source byte address.
REQ-007 SHALL have port dst_addr  input  32  destination byte address.
REQ-008 SHALL have port len  input  LEN_W  number of 32-bit words.
REQ-009 SHALL have port busy  output  1  transfer in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  one-cycle pulse on a misaligned request.
REQ-012 SHALL have port mem_addr  output  32  SRAM byte address.
REQ-013 SHALL have port mem_wdata  output  32  SRAM write data.
REQ-014 SHALL have port mem_rdata  input  32  SRAM read data, valid the cycle after a read strobe.
REQ-015 SHALL have port mem_en  output  1  SRAM access strobe.
REQ-016 SHALL have port mem_wr_en  output  1  write select, 0 = read.
REQ-017 SHALL have port mem_wr_mask  output  4  byte lanes; 4'hF on every write.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-019 In IDLE with start=1, SHALL latch src_addr, dst_addr and len, and clear the word counter.
REQ-020 If src_addr[1:0] or dst_addr[1:0] is nonzero at start, SHALL pulse err for one cycle, stay in IDLE and make no SRAM access.
REQ-021 If len==0 at start, SHALL go to DONE with no SRAM access.
REQ-022 READ SHALL drive mem_en=1, mem_wr_en=0, mem_addr=src+4*i, then go to WRITE.
REQ-023 WRITE SHALL drive mem_en=1, mem_wr_en=1, mem_wr_mask=4'hF, mem_addr=dst+4*i, mem_wdata=mem_rdata.
REQ-024 From WRITE, SHALL go to DONE if i==len-1; otherwise SHALL increment i and return to READ.
REQ-025 Throughput SHALL be 2 cycles per word; done SHALL assert exactly 2*len+1 cycles after the start cycle.
REQ-026 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-027 busy SHALL be 1 in READ and WRITE and 0 in IDLE and DONE.
REQ-028 mem_en SHALL be 0 outside READ and WRITE.
REQ-029 Address arithmetic SHALL be 32-bit modulo; wrap past 32'hFFFF_FFFC is legal.
REQ-030 Copy direction SHALL always be ascending; overlapping regions are not corrected.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort in READ or WRITE SHALL return to IDLE next cycle with no done pulse.
REQ-033 A write strobe already issued in the abort cycle SHALL complete; no further accesses SHALL be issued.
REQ-034 If abort and start are both 1 in IDLE, abort SHALL win and start SHALL be ignored.

Reset
REQ-035 rst SHALL force IDLE asynchronously.
REQ-036 In reset, busy, done, err, mem_en and mem_wr_en SHALL be 0; mem_addr, mem_wdata and mem_wr_mask SHALL be 0.
REQ-037 Reset mid-transfer SHALL abandon the transfer with no done pulse.

Configuration
REQ-038 Macro SPSRAM32_DMA_FILL_EN defined SHALL add ports fill (input, 1) and fill_data (input, 32), both latched at start.
REQ-039 With fill latched to 1, SHALL skip READ and write fill_data in consecutive WRITE cycles at 1 cycle per word; done SHALL assert len+1 cycles after start; src_addr alignment SHALL be ignored.
REQ-040 Macro undefined SHALL omit the fill ports and fill logic; copy behaviour SHALL be unchanged.

Structure
REQ-041 Package spsram32_pkg SHALL hold the dma_state_t enum and the constant WORD_BYTES=4.
REQ-042 No sub-module SHALL be used; the bench SHALL pair the DMA with spsram32_model as the SRAM.

Verification
REQ-043 Preload words 0..3 = 0x11111111..0x44444444; src=0x0, dst=0x40, len=4 -> dst words match, done 9 cycles after start, busy high 8 cycles.
REQ-044 src=0x2, len=4 -> err pulses one cycle, mem_en stays 0, busy stays 0.
REQ-045 len=0 -> done one cycle after start, no SRAM access.
REQ-046 len=8, abort asserted in the 5th busy cycle -> words 0-1 copied, word 2 unchanged, no done, IDLE next cycle.
REQ-047 rst asserted mid-transfer -> outputs 0 immediately; a new start after rst releases -> full copy.
REQ-048 With SPSRAM32_DMA_FILL_EN defined: fill=1, fill_data=0xDEADBEEF, dst=0x80, len=3 -> three words written, done 4 cycles after start.

Source files
------------

// File: rtl/spsram32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spsram32_pkg
// Purpose  : Shared state encoding and constants for the SPSRAM32 DMA engine.
// Revision : 1.0
// ============================================================================
package spsram32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    localparam int unsigned WORD_BYTES  = 32'd4;
    localparam logic [3:0]  WR_MASK_ALL = 4'hF;

endpackage : spsram32_pkg
`default_nettype wire

// File: rtl/spsram32_model.sv
`default_nettype none
// ============================================================================
// Module   : spsram32_model
// Purpose  : Single-port 32-bit SRAM with byte-lane writes and one-cycle
//            registered read latency. Word-indexed on address bits [DEPTH_W+1:2].
// Revision : 1.0
// ============================================================================
module spsram32_model #(
    parameter int DEPTH_W = 8
) (
    input  logic        clk,
    input  logic        i_en,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_mask,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0]        r_mem [2**DEPTH_W];
    logic [DEPTH_W-1:0] w_idx;
    logic               w_unused_addr;

    assign w_idx         = i_addr[DEPTH_W+1:2];
    assign w_unused_addr = &{1'b0, i_addr[31:DEPTH_W+2], i_addr[1:0]};

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_wr_mask[b]) begin
                        r_mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                o_rdata <= r_mem[w_idx];
            end
        end
    end

endmodule : spsram32_model
`default_nettype wire

// File: rtl/spsram32_dma.sv
`default_nettype none
// ============================================================================
// Module   : spsram32_dma
// Purpose  : Word-granular SRAM-to-SRAM copy engine, two cycles per word.
//            Optional SPSRAM32_DMA_FILL_EN adds a one-cycle-per-word fill mode.
// Revision : 1.0
// ============================================================================
module spsram32_dma
    import spsram32_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
`ifdef SPSRAM32_DMA_FILL_EN
    input  logic             fill,
    input  logic [31:0]      fill_data,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             mem_en,
    output logic             mem_wr_en,
    output logic [3:0]       mem_wr_mask
);

    dma_state_t       r_state;
    dma_state_t       w_state_nxt;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_err;

    logic             w_fill_req;
    logic             w_fill_mode;
    logic [31:0]      w_wr_data;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_offset;

`ifdef SPSRAM32_DMA_FILL_EN
    logic             r_fill;
    logic [31:0]      r_fill_data;

    assign w_fill_req  = fill;
    assign w_fill_mode = r_fill;
    assign w_wr_data   = r_fill ? r_fill_data : mem_rdata;
`else
    assign w_fill_req  = 1'b0;
    assign w_fill_mode = 1'b0;
    assign w_wr_data   = mem_rdata;
`endif

    // A fill never reads, so only the destination alignment matters there.
    assign w_misaligned = ((|src_addr[1:0]) & ~w_fill_req) | (|dst_addr[1:0]);
    assign w_accept     = (r_state == IDLE) & start & ~abort;
    assign w_last       = (r_cnt == (r_len - LEN_W'(1)));
    assign w_offset     = 32'(r_cnt) * WORD_BYTES;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
`ifdef SPSRAM32_DMA_FILL_EN
            r_fill      <= 1'b0;
            r_fill_data <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept & w_misaligned;
            if (w_accept) begin
                r_src <= src_addr;
                r_dst <= dst_addr;
                r_len <= len;
                r_cnt <= '0;
`ifdef SPSRAM32_DMA_FILL_EN
                r_fill      <= fill;
                r_fill_data <= fill_data;
`endif
            end else if ((r_state == WRITE) && !abort && !w_last) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_misaligned) begin
                    if (len == '0) begin
                        w_state_nxt = DONE;
                    end else if (w_fill_req) begin
                        w_state_nxt = WRITE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            READ: begin
                w_state_nxt = abort ? IDLE : WRITE;
            end
            WRITE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end else if (w_fill_mode) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = READ;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus outputs decode straight from state so reset zeroes them at once.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        err         = r_err;
        mem_en      = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_mask = 4'h0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            READ: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = r_src + w_offset;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_en      = 1'b1;
                mem_wr_en   = 1'b1;
                mem_wr_mask = WR_MASK_ALL;
                mem_addr    = r_dst + w_offset;
                mem_wdata   = w_wr_data;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule : spsram32_dma
`default_nettype wire

// File: tb/tb_spsram32_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_spsram32_dma
// Purpose  : Scoreboard bench pairing spsram32_dma with spsram32_model.
// Revision : 1.0
// ============================================================================
module tb_spsram32_dma;

    localparam int EV_R    = 0;
    localparam int EV_W    = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        fill = 1'b0;
    logic [31:0] fill_data = '0;
    logic        busy, done, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr_en;
    logic [3:0]  mem_wr_mask;

    logic        tb_sel = 1'b0;
    logic        tb_en = 1'b0;
    logic        tb_wr = 1'b0;
    logic [31:0] tb_addr = '0;
    logic [31:0] tb_wdata = '0;
    logic        sram_en, sram_wr;
    logic [3:0]  sram_mask;
    logic [31:0] sram_addr, sram_wdata;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    ev_t         sb[$];
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sram_en    = tb_sel ? tb_en    : mem_en;
    assign sram_wr    = tb_sel ? tb_wr    : mem_wr_en;
    assign sram_mask  = tb_sel ? 4'hF     : mem_wr_mask;
    assign sram_addr  = tb_sel ? tb_addr  : mem_addr;
    assign sram_wdata = tb_sel ? tb_wdata : mem_wdata;

    spsram32_dma #(.LEN_W(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
`ifdef SPSRAM32_DMA_FILL_EN
        .fill        (fill),
        .fill_data   (fill_data),
`endif
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_en      (mem_en),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_mask (mem_wr_mask)
    );

    spsram32_model #(.DEPTH_W(8)) u_mem (
        .clk       (clk),
        .i_en      (sram_en),
        .i_wr_en   (sram_wr),
        .i_wr_mask (sram_mask),
        .i_addr    (sram_addr),
        .i_wdata   (sram_wdata),
        .o_rdata   (mem_rdata)
    );

    function automatic int ridx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        bit  bad;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d addr=%h data=%h cycle=%0d", kind, a, d, cyc);
        end else begin
            e   = sb.pop_front();
            bad = (e.kind != kind) || (e.cyc != cyc);
            if (kind == EV_R || kind == EV_W) bad = bad || (e.addr !== a);
            if (kind == EV_W) bad = bad || (e.data !== d);
            if (bad) begin
                errors++;
                $display("FAIL event got kind=%0d cyc=%0d addr=%h data=%h expected kind=%0d cyc=%0d addr=%h data=%h",
                         kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every visible DUT response is matched against the scoreboard.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (mem_en) begin
            observe(mem_wr_en ? EV_W : EV_R, mem_addr, mem_wdata);
            if (mem_wr_en) chk("wr_mask", 64'(mem_wr_mask), 64'h0F);
        end
        if (done) observe(EV_DONE, 32'h0, 32'h0);
        if (err)  observe(EV_ERR, 32'h0, 32'h0);
    end

    task automatic tb_write(input int idx, input logic [31:0] d);
        tb_sel = 1'b1; tb_en = 1'b1; tb_wr = 1'b1;
        tb_addr = 32'(idx) << 2; tb_wdata = d;
        @(posedge clk); #1;
        tb_en = 1'b0; tb_wr = 1'b0; tb_sel = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic tb_read(input int idx, output logic [31:0] d);
        tb_sel = 1'b1; tb_en = 1'b1; tb_wr = 1'b0;
        tb_addr = 32'(idx) << 2;
        @(posedge clk); #1;
        d = mem_rdata;
        tb_en = 1'b0; tb_sel = 1'b0;
    endtask

    // One transfer: expected events come from word-by-word copy semantics,
    // truncated at the abort or reset cut-off cycle.
    task automatic run(input logic [31:0] src, input logic [31:0] dst, input int n,
                       input bit fl, input logic [31:0] fd, input int abort_at,
                       input int rst_at, input bit inj, input bit both);
        int          s, full, cutoff, exp_busy, rc, wc;
        bit          mis;
        logic [31:0] d, sa, da;
        s      = cyc;
        mis    = fl ? (dst[1:0] != 2'b00) : ((src[1:0] | dst[1:0]) != 2'b00);
        full   = fl ? n : 2 * n;
        cutoff = (abort_at > 0) ? s + abort_at + 1 : ((rst_at > 0) ? s + rst_at : 32'h7fffffff);
        exp_busy = 0;
        if (!both && mis) begin
            sb.push_back('{kind: EV_ERR, cyc: s + 1, addr: 32'h0, data: 32'h0});
        end else if (!both) begin
            for (int k = 0; k < n; k++) begin
                sa = src + 32'(4 * k);
                da = dst + 32'(4 * k);
                rc = s + 1 + 2 * k;
                wc = fl ? s + 1 + k : s + 2 + 2 * k;
                if (!fl && rc < cutoff) sb.push_back('{kind: EV_R, cyc: rc, addr: sa, data: 32'h0});
                if (wc < cutoff) begin
                    d = fl ? fd : ref_mem[ridx(sa)];
                    ref_mem[ridx(da)] = d;
                    sb.push_back('{kind: EV_W, cyc: wc, addr: da, data: d});
                end
            end
            if (s + full + 1 < cutoff) sb.push_back('{kind: EV_DONE, cyc: s + full + 1, addr: 32'h0, data: 32'h0});
            exp_busy = (full < cutoff - s - 1) ? full : cutoff - s - 1;
        end
        busy_cnt = 0;
        for (int c = s; c <= s + full + 3; c++) begin
            start = (c == s) || (inj && c == s + 1);
            if (c == s) begin
                src_addr = src; dst_addr = dst; len = 16'(n); fill = fl; fill_data = fd;
            end else if (inj && c == s + 1) begin
                src_addr = $urandom; dst_addr = $urandom; len = 16'($urandom_range(1, 9));
                fill = 1'($urandom); fill_data = $urandom;
            end
            abort = (both && c == s) || (abort_at > 0 && c == s + abort_at);
            rst   = (rst_at > 0 && c == s + rst_at);
            if (rst) begin
                #1;
                chk("rst_ctrl", 64'({busy, done, err, mem_en, mem_wr_en}), 64'h0);
                chk("rst_addr", 64'(mem_addr), 64'h0);
                chk("rst_wdata_mask", 64'({mem_wr_mask, mem_wdata}), 64'h0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        chk("pending_events", 64'(sb.size()), 64'h0);
        chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        sb.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          n, mode, ab;
        bit          fl;
        logic [31:0] src, dst;
        #3;
        chk("reset_ctrl", 64'({busy, done, err, mem_en, mem_wr_en}), 64'h0);
        chk("reset_bus", 64'({mem_wr_mask, mem_addr}), 64'h0);
        chk("reset_wdata", 64'(mem_wdata), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) tb_write(i, $urandom);
        tb_write(0, 32'h11111111); tb_write(1, 32'h22222222);
        tb_write(2, 32'h33333333); tb_write(3, 32'h44444444);

        run(32'h0, 32'h40, 4, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
        run(32'h2, 32'h80, 4, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
        run(32'h10, 32'h20, 0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
        run(32'h0, 32'h100, 8, 1'b0, 32'h0, 5, 0, 1'b0, 1'b0);
        run(32'h0, 32'h200, 6, 1'b0, 32'h0, 0, 5, 1'b0, 1'b0);
        run(32'h0, 32'h200, 6, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
        run(32'h0, 32'h300, 3, 1'b0, 32'h0, 0, 0, 1'b0, 1'b1);
        run(32'hFFFF_FFF8, 32'h3E0, 4, 1'b0, 32'h0, 0, 0, 1'b1, 1'b0);
        run(32'h0, 32'h2F8, 6, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
`ifdef SPSRAM32_DMA_FILL_EN
        run(32'h1, 32'h80, 3, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0);
        run(32'h0, 32'h81, 3, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 40; t++) begin
            n    = $urandom_range(0, 12);
            mode = $urandom_range(0, 9);
            src  = $urandom & 32'hFFFF_FFFC;
            dst  = $urandom & 32'hFFFF_FFFC;
            fl   = 1'b0;
`ifdef SPSRAM32_DMA_FILL_EN
            fl   = ($urandom_range(0, 2) == 0);
`endif
            if (mode == 0) begin
                if ($urandom_range(0, 1) == 1) src = src | 32'($urandom_range(1, 3));
                else dst = dst | 32'($urandom_range(1, 3));
            end
            ab = 0;
            if (mode == 1 && n > 0) ab = $urandom_range(1, fl ? n : 2 * n);
            run(src, dst, n, fl, $urandom, ab, 0,
                (mode >= 7) && (n > 0) && !(fl ? (dst[1:0] != 0) : ((src[1:0] | dst[1:0]) != 0)),
                mode == 2);
        end

        for (int i = 0; i < 256; i++) begin
            tb_read(i, rd);
            chk($sformatf("mem_word_%0d", i), 64'(rd), 64'(ref_mem[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spsram32_dma
`default_nettype wire
